// File: rtl/lamp_pkg.sv
// lamp_pkg: scheduler state type, mode encoding and shared counter width
// for the lamp_sched block and its tick prescaler.
package lamp_pkg;

    // Scheduler states; DRAIN waits for the light FSM to reach all-off.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEFT  = 3'd1,
        ST_RIGHT = 3'd2,
        ST_HAZ   = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    // Encoding of the mode output.
    localparam logic [1:0] MODE_IDLE  = 2'd0;
    localparam logic [1:0] MODE_LEFT  = 2'd1;
    localparam logic [1:0] MODE_RIGHT = 2'd2;
    localparam logic [1:0] MODE_HAZ   = 2'd3;

    // All counters hold values up to 255.
    localparam int CNT_W = 8;

    // Mode reported for a state; IDLE and DRAIN both report no active mode.
    function automatic logic [1:0] mode_of(state_e s);
        case (s)
            ST_LEFT:  return MODE_LEFT;
            ST_RIGHT: return MODE_RIGHT;
            ST_HAZ:   return MODE_HAZ;
            default:  return MODE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/lamp_sched_if.sv
// lamp_sched_if: request/cancel inputs and light-drive outputs of the
// lamp scheduler. master = request source, slave = scheduler.
interface lamp_sched_if;
    logic       req_left;
    logic       req_right;
    logic       req_haz;
    logic       cancel;
    logic       seq_done;
    logic       left;
    logic       right;
    logic       hazards;
    logic       tick;
    logic [1:0] mode;

    modport master (
        output req_left, req_right, req_haz, cancel, seq_done,
        input  left, right, hazards, tick, mode
    );

    modport slave (
        input  req_left, req_right, req_haz, cancel, seq_done,
        output left, right, hazards, tick, mode
    );
endinterface

// File: rtl/lamp_tick.sv
// lamp_tick: free-running prescaler counting 0..DIV-1; tick is high on the
// cycle the count equals DIV-1.
module lamp_tick
    import lamp_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Wrap after the last count of the period.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/lamp_sched.sv
// lamp_sched: chooses which lamp sequence (left, right, hazard) the light
// FSM runs, holds each mode for MIN_TICKS ticks before honouring cancel,
// and drains through all-off before returning to idle.
// Optional feature: define LAMP_SCHED_TIMEOUT_EN to let DRAIN also exit
// after DRAIN_MAX ticks without seq_done.
module lamp_sched
    import lamp_pkg::*;
#(
    parameter int DIV       = 4,
    parameter int MIN_TICKS = 2,
    parameter int DRAIN_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    lamp_sched_if.slave bus
);

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MIN_TICKS);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             pend_q, pend_d;
    logic             canc_q, canc_d;
    logic             left_q, right_q, haz_q;
    logic [1:0]       mode_q;
    logic             tick;
    logic             active;
    logic             hold_full;
    logic             cancel_any;
    logic             drain_expired;

    lamp_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign active     = (state_q == ST_LEFT) || (state_q == ST_RIGHT) || (state_q == ST_HAZ);
    assign hold_full  = (hold_q >= HOLD_MAX);
    assign cancel_any = bus.cancel || canc_q;

`ifdef LAMP_SCHED_TIMEOUT_EN
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_MAX - 1);

    logic [CNT_W-1:0] drain_q, drain_d;

    assign drain_expired = tick && (drain_q == DRAIN_LAST);

    // Count ticks spent in DRAIN; restart whenever DRAIN is left or entered.
    always_comb begin
        drain_d = '0;
        if ((state_q == ST_DRAIN) && (state_d == ST_DRAIN)) begin
            drain_d = tick ? drain_q + 1'b1 : drain_q;
        end
    end

    // Drain tick counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drain_q <= '0;
        end else begin
            drain_q <= drain_d;
        end
    end
`else
    // DRAIN_MAX only matters when the drain timeout is built in.
    logic unused_drain_max;
    assign unused_drain_max = (DRAIN_MAX > 0);
    assign drain_expired    = 1'b0;
`endif

    // Next state, hold counter, pending-switch and latched-cancel flags.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pend_d  = pend_q;
        canc_d  = canc_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_haz || (bus.req_left && bus.req_right)) begin
                    state_d = ST_HAZ;
                end else if (bus.req_left) begin
                    state_d = ST_LEFT;
                end else if (bus.req_right) begin
                    state_d = ST_RIGHT;
                end
            end
            ST_LEFT, ST_RIGHT: begin
                if (bus.req_haz) begin
                    state_d = ST_HAZ;
                end else if (cancel_any) begin
                    // Cancel always beats a pending switch, even on seq_done.
                    pend_d = 1'b0;
                    if (hold_full) begin
                        state_d = ST_DRAIN;
                    end else begin
                        canc_d = 1'b1;
                    end
                end else if (pend_q && bus.seq_done) begin
                    state_d = (state_q == ST_LEFT) ? ST_RIGHT : ST_LEFT;
                end else if ((state_q == ST_LEFT) ? bus.req_right : bus.req_left) begin
                    pend_d = 1'b1;
                end
            end
            ST_HAZ: begin
                if (cancel_any) begin
                    if (bus.req_haz) begin
                        // Hazard still requested: the cancel is dropped.
                        canc_d = 1'b0;
                    end else if (hold_full) begin
                        state_d = ST_DRAIN;
                    end else begin
                        canc_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.seq_done || drain_expired) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Any state change starts the new state with fresh counters and flags.
        if (state_d != state_q) begin
            hold_d = '0;
            pend_d = 1'b0;
            canc_d = 1'b0;
        end else if (active && tick && !hold_full) begin
            hold_d = hold_q + 1'b1;
        end
    end

    // State, hold counter and flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            pend_q  <= 1'b0;
            canc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            pend_q  <= pend_d;
            canc_q  <= canc_d;
        end
    end

    // Light drives follow the state register by one cycle; at most one is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            left_q  <= 1'b0;
            right_q <= 1'b0;
            haz_q   <= 1'b0;
            mode_q  <= MODE_IDLE;
        end else begin
            left_q  <= (state_q == ST_LEFT);
            right_q <= (state_q == ST_RIGHT);
            haz_q   <= (state_q == ST_HAZ);
            mode_q  <= mode_of(state_q);
        end
    end

    assign bus.left    = left_q;
    assign bus.right   = right_q;
    assign bus.hazards = haz_q;
    assign bus.mode    = mode_q;
    assign bus.tick    = tick;

endmodule

// File: tb/tb_lamp_sched.sv
// tb_lamp_sched: vector table, directed corner sequences and random
// stimulus for lamp_sched, checked against a behavioural model.
module tb_lamp_sched;

    localparam int DIV       = 4;
    localparam int MIN_TICKS = 2;
    localparam int DRAIN_MAX = 8;

    logic clk = 1'b0;
    logic reset;

    lamp_sched_if bus();

    lamp_sched #(
        .DIV       (DIV),
        .MIN_TICKS (MIN_TICKS),
        .DRAIN_MAX (DRAIN_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: st 0 idle, 1 left, 2 right, 3 hazard, 4 drain.
    int m_st, m_hold, m_drain, m_phase;
    bit m_pend, m_latch;
    int e_left, e_right, e_haz, e_mode;

    typedef struct {
        bit rl, rr, rh, c, sd;
        bit el, er, eh, et;
        int em;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_st = 0; m_hold = 0; m_drain = 0; m_phase = 0;
        m_pend = 0; m_latch = 0;
        e_left = 0; e_right = 0; e_haz = 0; e_mode = 0;
    endfunction

    // One rising edge of the reference: outputs show the state held before it.
    function automatic void model_edge();
        bit rl   = bus.req_left;
        bit rr   = bus.req_right;
        bit rh   = bus.req_haz;
        bit c    = bus.cancel;
        bit sd   = bus.seq_done;
        bit t    = (m_phase == DIV - 1);
        bit held = (m_hold >= MIN_TICKS);
        int nxt  = m_st;
        e_left  = (m_st == 1);
        e_right = (m_st == 2);
        e_haz   = (m_st == 3);
        e_mode  = (m_st == 4) ? 0 : m_st;
        if (m_st == 0) begin
            if (rh || (rl && rr)) nxt = 3;
            else if (rl) nxt = 1;
            else if (rr) nxt = 2;
        end else if (m_st == 1 || m_st == 2) begin
            if (rh) nxt = 3;
            else if (c || m_latch) begin
                m_pend = 0;
                if (held) nxt = 4; else m_latch = 1;
            end else if (m_pend && sd) nxt = 3 - m_st;
            else if ((m_st == 1 && rr) || (m_st == 2 && rl)) m_pend = 1;
        end else if (m_st == 3) begin
            if (c || m_latch) begin
                if (rh) m_latch = 0;
                else if (held) nxt = 4;
                else m_latch = 1;
            end
        end else begin
            if (sd) nxt = 0;
`ifdef LAMP_SCHED_TIMEOUT_EN
            else if (t) begin
                m_drain++;
                if (m_drain == DRAIN_MAX) nxt = 0;
            end
`endif
        end
        if (nxt != m_st) begin
            m_hold = 0; m_pend = 0; m_latch = 0; m_drain = 0;
        end else if (m_st >= 1 && m_st <= 3 && t && m_hold < MIN_TICKS) begin
            m_hold++;
        end
        m_st    = nxt;
        m_phase = (m_phase + 1) % DIV;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("left",    bus.left,    e_left);
        chk("right",   bus.right,   e_right);
        chk("hazards", bus.hazards, e_haz);
        chk("mode",    bus.mode,    e_mode);
        chk("tick",    bus.tick,    (m_phase == DIV - 1));
        chk("exclusive", (bus.left & bus.right) | (bus.left & bus.hazards) | (bus.right & bus.hazards), 0);
    endtask

    task automatic clear_inputs();
        bus.req_left = 0; bus.req_right = 0; bus.req_haz = 0;
        bus.cancel = 0; bus.seq_done = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        model_reset();
        #1;
        chk("rst_left",    bus.left,    0);
        chk("rst_right",   bus.right,   0);
        chk("rst_hazards", bus.hazards, 0);
        chk("rst_mode",    bus.mode,    0);
        chk("rst_tick",    bus.tick,    0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [17];
        int   n;
        //            rl rr rh c  sd  el er eh et  mode
        tbl[0]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0,  0};
        tbl[1]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0,  0};
        tbl[2]  = '{1, 0, 0, 0, 0,  1, 0, 0, 1,  1};
        tbl[3]  = '{0, 1, 0, 0, 0,  1, 0, 0, 0,  1};
        tbl[4]  = '{0, 0, 0, 0, 1,  1, 0, 0, 0,  1};
        tbl[5]  = '{0, 0, 0, 0, 0,  0, 1, 0, 0,  2};
        tbl[6]  = '{0, 0, 1, 0, 0,  0, 1, 0, 1,  2};
        tbl[7]  = '{0, 0, 1, 0, 0,  0, 0, 1, 0,  3};
        tbl[8]  = '{0, 0, 0, 1, 0,  0, 0, 1, 0,  3};
        tbl[9]  = '{0, 0, 0, 0, 0,  0, 0, 1, 0,  3};
        tbl[10] = '{0, 0, 0, 0, 0,  0, 0, 1, 1,  3};
        tbl[11] = '{0, 0, 0, 0, 0,  0, 0, 1, 0,  3};
        tbl[12] = '{0, 0, 0, 0, 0,  0, 0, 1, 0,  3};
        tbl[13] = '{1, 0, 0, 0, 0,  0, 0, 0, 0,  0};
        tbl[14] = '{0, 0, 0, 0, 1,  0, 0, 0, 1,  0};
        tbl[15] = '{1, 1, 0, 0, 0,  0, 0, 0, 0,  0};
        tbl[16] = '{0, 0, 0, 0, 0,  0, 0, 1, 0,  3};

        do_reset();
        for (int i = 0; i < 17; i++) begin
            bus.req_left  = tbl[i].rl;
            bus.req_right = tbl[i].rr;
            bus.req_haz   = tbl[i].rh;
            bus.cancel    = tbl[i].c;
            bus.seq_done  = tbl[i].sd;
            cycle();
            chk($sformatf("vec%0d_left", i),    bus.left,    tbl[i].el);
            chk($sformatf("vec%0d_right", i),   bus.right,   tbl[i].er);
            chk($sformatf("vec%0d_hazards", i), bus.hazards, tbl[i].eh);
            chk($sformatf("vec%0d_tick", i),    bus.tick,    tbl[i].et);
            chk($sformatf("vec%0d_mode", i),    bus.mode,    tbl[i].em);
        end
        clear_inputs();

        // Cancel one tick into LEFT is held off until the second tick.
        do_reset();
        bus.req_left = 1; cycle(); bus.req_left = 0;
        cycle();
        chk("a_left_on", bus.left, 1);
        n = 0;
        while (!bus.tick && n < 10) begin cycle(); n++; end
        chk("a_tick_seen", (n < 10), 1);
        bus.cancel = 1; cycle(); bus.cancel = 0;
        n = 0;
        while (bus.left && n < 20) begin cycle(); n++; end
        chk("a_cycles_until_drain", n, 6);
        chk("a_drain_mode", bus.mode, 0);
        bus.req_left = 1; cycle(); cycle();
        chk("a_drain_ignores_req", bus.left, 0);
        bus.req_left = 0; bus.seq_done = 1; cycle(); bus.seq_done = 0;
        cycle();
        bus.req_left = 1; cycle(); cycle();
        chk("a_idle_again", bus.left, 1);
        chk("a_idle_again_mode", bus.mode, 1);
        clear_inputs();

        // Hazard preempts RIGHT without overlapping drives.
        do_reset();
        bus.req_right = 1; cycle(); cycle(); cycle();
        chk("b_right_on", bus.right, 1);
        bus.req_haz = 1; cycle();
        chk("b_no_overlap", bus.right & bus.hazards, 0);
        cycle();
        chk("b_haz_on", bus.hazards, 1);
        chk("b_right_off", bus.right, 0);
        chk("b_mode", bus.mode, 3);
        clear_inputs();

        // DRAIN with seq_done held low.
        do_reset();
        bus.req_left = 1; cycle(); bus.req_left = 0;
        repeat (12) cycle();
        bus.cancel = 1; cycle(); bus.cancel = 0;
        cycle(); cycle();
        chk("d_in_drain", bus.left, 0);
`ifdef LAMP_SCHED_TIMEOUT_EN
        repeat (40) cycle();
        bus.req_left = 1; cycle(); cycle();
        chk("d_timeout_exit", bus.left, 1);
`else
        repeat (100) cycle();
        bus.req_left = 1; cycle(); cycle(); cycle();
        chk("d_still_drain", bus.left, 0);
        bus.seq_done = 1; cycle(); bus.seq_done = 0;
        cycle(); cycle();
        chk("d_exit_on_seq_done", bus.left, 1);
`endif
        clear_inputs();

        // Reset mid-HAZ clears outputs without a clock edge.
        do_reset();
        bus.req_haz = 1; cycle(); cycle();
        chk("e_haz_on", bus.hazards, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("e_async_hazards", bus.hazards, 0);
        chk("e_async_mode",    bus.mode,    0);
        chk("e_async_tick",    bus.tick,    0);
        bus.req_haz = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("e_mode_idle", bus.mode, 0);
        end

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0)  bus.req_left  = ~bus.req_left;
            if ($urandom_range(7) == 0)  bus.req_right = ~bus.req_right;
            if ($urandom_range(19) == 0) bus.req_haz   = ~bus.req_haz;
            bus.cancel   = ($urandom_range(9) == 0);
            bus.seq_done = ($urandom_range(5) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lamp_sched.md
LAMP_SCHED -- requirements
Module: lamp_sched

Interface
REQ-001 Parameter DIV, default 4: clk cycles per tick, legal range 2..255.
REQ-002 Parameter MIN_TICKS, default 2: minimum ticks an active mode is held before cancel is honoured.
REQ-003 Parameter DRAIN_MAX, default 8: drain timeout in ticks.
REQ-004 clk  in  1  single system clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_left  in  1  left-turn request level.
REQ-007 req_right  in  1  right-turn request level.
REQ-008 req_haz  in  1  hazard request level.
REQ-009 cancel  in  1  one-cycle pulse ending the current mode.
REQ-010 seq_done  in  1  pulse from the light FSM when its sequence returns to all-off.
REQ-011 left  out  1  drive to the light FSM left input, registered.
REQ-012 right  out  1  drive to the light FSM right input, registered.
REQ-013 hazards  out  1  drive to the light FSM hazards input, registered.
REQ-014 tick  out  1  one-cycle pace pulse, every DIV clk cycles.
REQ-015 mode  out  2  current mode: 0 idle, 1 left, 2 right, 3 hazard.

Function
REQ-016 Tick counter SHALL count 0..DIV-1 and wrap; tick SHALL be high on the cycle the count equals DIV-1.
REQ-017 States SHALL be IDLE, LEFT, RIGHT, HAZ and DRAIN.
REQ-018 IDLE SHALL go to HAZ on req_haz, or on req_left and req_right together, as hazard takes priority.
REQ-019 IDLE SHALL go to LEFT on req_left alone and to RIGHT on req_right alone.
REQ-020 On entry to LEFT, RIGHT or HAZ, the hold counter SHALL clear; it SHALL increment on each tick and saturate at MIN_TICKS.
REQ-021 From LEFT or RIGHT, req_haz SHALL move the block to HAZ on the next clock, regardless of the hold counter.
REQ-022 From LEFT, req_right SHALL set a pending-switch flag; from RIGHT, req_left SHALL set it; the switch SHALL occur on the next seq_done.
REQ-023 cancel in LEFT, RIGHT or HAZ with hold counter below MIN_TICKS SHALL be latched and honoured once the hold counter reaches MIN_TICKS.
REQ-024 An honoured cancel SHALL move the block to DRAIN.
REQ-025 In HAZ, cancel SHALL be honoured only while req_haz is low; otherwise it SHALL be discarded.
REQ-026 A pending switch SHALL clear on cancel, on preemption to HAZ, or when the switch completes.
REQ-027 In DRAIN, left, right and hazards SHALL all be 0.
REQ-028 DRAIN SHALL go to IDLE on seq_done.
REQ-029 Outputs SHALL be registered, one cycle after the state register: LEFT gives left=1, RIGHT gives right=1, HAZ gives hazards=1, and no two outputs SHALL be high together.
REQ-030 When seq_done and cancel arrive in the same cycle, cancel SHALL win over a pending switch.

Reset
REQ-031 Reset SHALL force state IDLE, all outputs 0, mode=0, tick=0, all counters 0, and pending and latched-cancel flags 0.
REQ-032 Reset asserted mid-mode SHALL take effect immediately, without waiting for a clock edge or a drain.

Configuration
REQ-033 With LAMP_SCHED_TIMEOUT_EN defined, DRAIN SHALL also exit to IDLE after DRAIN_MAX ticks without seq_done.
REQ-034 Without LAMP_SCHED_TIMEOUT_EN, DRAIN SHALL wait for seq_done indefinitely, and the drain counter SHALL not exist.

Structure
REQ-035 Package lamp_pkg SHALL hold the state enum type and the mode encoding constants.
REQ-036 The tick prescaler SHALL be a sub-module, lamp_tick, with ports clk, reset and tick.

Verification
REQ-037 Reset for 4 cycles, then req_left=1 -> mode=1 and left=1 two cycles after the request; tick period is 4 cycles.
REQ-038 In LEFT, pulse cancel one tick after entry -> the block stays in LEFT until the 2nd tick, then enters DRAIN; seq_done -> IDLE.
REQ-039 In RIGHT, raise req_haz -> hazards=1 and right=0 within 2 cycles, with no cycle where both are high.
REQ-040 Assert req_left and req_right together from IDLE -> mode=3; in LEFT, req_right then seq_done -> mode=2.
REQ-041 With LAMP_SCHED_TIMEOUT_EN defined, enter DRAIN with seq_done held low -> IDLE after 8 ticks; without the macro -> the block is still in DRAIN after 100 cycles.
REQ-042 Assert reset mid-HAZ -> all outputs 0 in the same cycle; after release with no requests, mode stays 0.
